// File: rtl/bit_serial_pkg.sv
// -----------------------------------------------------------------------------
// bit_serial_pkg
// Shared types for the bit-serial lane engine: opcode and FSM state enums,
// the opcode width, and a helper that says whether an opcode is executable.
// Configuration macro: BIT_SERIAL_ADD_EN (when undefined, ADD is not
// executable and is reported as illegal).
// -----------------------------------------------------------------------------
package bit_serial_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_ADD  = 3'd3,
        OP_MUX  = 3'd4,
        OP_GXOR = 3'd5,
        OP_REV  = 3'd6,
        OP_ILL  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // True when the engine cannot execute this opcode; such an operation
    // produces an all-zero result with the error flag set.
    function automatic logic op_illegal(op_e op);
`ifdef BIT_SERIAL_ADD_EN
        return (op == OP_ILL);
`else
        return (op == OP_ILL) || (op == OP_ADD);
`endif
    endfunction

endpackage

// File: rtl/bit_serial_cell.sv
// -----------------------------------------------------------------------------
// bit_serial_cell
// Combinational single-lane ALU used by the bit-serial engine.
// Ports:
//   op    in  opcode (op_e)
//   a     in  lane bit of operand A (already bit-reversed by the caller for REV)
//   b     in  lane bit of operand B
//   sel   in  mux select / gate enable
//   cin   in  carry in   (only with BIT_SERIAL_ADD_EN)
//   cout  out carry out  (only with BIT_SERIAL_ADD_EN)
//   y     out lane result
// Configuration macro: BIT_SERIAL_ADD_EN enables the ADD lane and carry ports.
// -----------------------------------------------------------------------------
module bit_serial_cell
    import bit_serial_pkg::*;
(
    input  op_e  op,
    input  logic a,
    input  logic b,
    input  logic sel,
`ifdef BIT_SERIAL_ADD_EN
    input  logic cin,
    output logic cout,
`endif
    output logic y
);

    always_comb begin
        y = 1'b0;
`ifdef BIT_SERIAL_ADD_EN
        cout = 1'b0;
`endif
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
`ifdef BIT_SERIAL_ADD_EN
            OP_ADD: begin
                y    = a ^ b ^ cin;
                cout = (a & b) | (cin & (a ^ b));
            end
`endif
            OP_MUX:  y = sel ? a : b;
            OP_GXOR: y = (a ^ b) & sel;
            OP_REV:  y = a;
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/bit_serial_lane_engine.sv
// -----------------------------------------------------------------------------
// bit_serial_lane_engine
// Accepts one WIDTH-bit operation and evaluates it one bit lane per cycle,
// LSB first, packing the lane results into a WIDTH-bit vector. Every opcode
// takes exactly WIDTH RUN cycles.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   request handshake (ready only in IDLE)
//   in_op, in_a, in_b,
//   in_sel                request payload, latched on accept
//   out_valid / out_ready result handshake (valid only in DONE)
//   out_data              packed result
//   out_carry             final carry of ADD, 0 otherwise
//   out_err               opcode illegal/unsupported (out_data is then 0)
// Configuration macro: BIT_SERIAL_ADD_EN (ADD and the carry flop exist only
// when defined; otherwise opcode 3 is illegal and out_carry is tied 0).
// -----------------------------------------------------------------------------
module bit_serial_lane_engine
    import bit_serial_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_err
);

    localparam int IDX_W = $clog2(WIDTH);

    state_e             state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    op_e                op_reg;
    logic               sel_reg;
    logic [WIDTH-1:0]   out_data_reg;
    logic               out_err_reg;
`ifdef BIT_SERIAL_ADD_EN
    logic               carry_reg;
    logic               out_carry_reg;
    logic               lane_cout;
`endif

    logic [WIDTH-1:0]   a_rev;
    logic               lane_a;
    logic               lane_y;
    logic               last_lane;

    // Bit-reversed copy of A so REV can reuse the plain "y = a" lane.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
        assign a_rev[gi] = a_reg[WIDTH-1-gi];
    end

    assign lane_a    = (op_reg == OP_REV) ? a_rev[idx_reg] : a_reg[idx_reg];
    assign last_lane = (idx_reg == IDX_W'(WIDTH - 1));

    bit_serial_cell u_cell (
        .op   (op_reg),
        .a    (lane_a),
        .b    (b_reg[idx_reg]),
        .sel  (sel_reg),
`ifdef BIT_SERIAL_ADD_EN
        .cin  (carry_reg),
        .cout (lane_cout),
`endif
        .y    (lane_y)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_lane) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            op_reg        <= OP_AND;
            sel_reg       <= 1'b0;
            out_data_reg  <= '0;
            out_err_reg   <= 1'b0;
`ifdef BIT_SERIAL_ADD_EN
            carry_reg     <= 1'b0;
            out_carry_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg         <= in_a;
                        b_reg         <= in_b;
                        op_reg        <= op_e'(in_op);
                        sel_reg       <= in_sel;
                        idx_reg       <= '0;
                        out_data_reg  <= '0;
                        out_err_reg   <= 1'b0;
`ifdef BIT_SERIAL_ADD_EN
                        carry_reg     <= 1'b0;
                        out_carry_reg <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    out_data_reg[idx_reg] <= lane_y;
`ifdef BIT_SERIAL_ADD_EN
                    carry_reg <= lane_cout;
`endif
                    if (last_lane) begin
                        // Index stays at WIDTH-1; the next accept reloads it.
                        out_err_reg <= op_illegal(op_reg);
`ifdef BIT_SERIAL_ADD_EN
                        out_carry_reg <= lane_cout;
`endif
                    end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign out_data  = out_data_reg;
    assign out_err   = out_err_reg;
`ifdef BIT_SERIAL_ADD_EN
    assign out_carry = out_carry_reg;
`else
    assign out_carry = 1'b0;
`endif

endmodule
